// File: rtl/tt_memop_sync_pkg.sv
// Shared types and constants for the vector-memop sync responder.
// Holds the FSM encoding, the sync status codes and the counter-width helper.
package tt_memop_sync_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2,
        END    = 2'd3
    } memop_sync_state_t;

    localparam logic SYNC_OK    = 1'b0;
    localparam logic SYNC_FAULT = 1'b1;

    function automatic int cnt_width(input int max_outstanding);
        return $clog2(max_outstanding + 1);
    endfunction

endpackage

// File: rtl/tt_outstanding_counter.sv
// Saturating up/down counter of in-flight memory requests.
// Overflow/underflow flag attempts that were clamped in the current cycle.
module tt_outstanding_counter
    import tt_memop_sync_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 16,
    parameter int CNT_W           = cnt_width(MAX_OUTSTANDING)
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             next_is_zero,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] count_nxt;

    // A simultaneous inc and dec cancel, so they can never over/underflow.
    always_comb begin
        count_nxt = count;
        overflow  = 1'b0;
        underflow = 1'b0;
        if (inc && !dec) begin
            if (count == CNT_MAX) begin
                overflow = 1'b1;
            end else begin
                count_nxt = count + CNT_ONE;
            end
        end else if (dec && !inc) begin
            if (count == '0) begin
                underflow = 1'b1;
            end else begin
                count_nxt = count - CNT_ONE;
            end
        end
    end

    assign next_is_zero = (count_nxt == '0);

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            count <= '0;
        end else begin
            count <= count_nxt;
        end
    end

endmodule

// File: rtl/tt_memop_sync_responder.sv
// Memory-side responder for the VPU vector-memop sync handshake: tracks one
// memop from issue until its requests drain, then pulses o_sync_end with status.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | no memop in flight; waiting for an issue
//   ACTIVE | memop issued; counting requests/responses, awaiting sync
//   DRAIN  | sync requested; waiting for outstanding count to reach zero
//   END    | one-cycle o_sync_end pulse with status and vstart
module tt_memop_sync_responder
    import tt_memop_sync_pkg::*;
#(
    parameter  int MAX_OUTSTANDING = 16,
    parameter  int VSTART_W        = 11,
    localparam int CNT_W           = cnt_width(MAX_OUTSTANDING)
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_issue_valid,
    input  logic                i_issue_store,
    input  logic                i_req_valid,
    input  logic                i_resp_valid,
    input  logic                i_resp_fault,
    input  logic [VSTART_W-1:0] i_resp_elem,
    input  logic                i_sync_start,
    output logic                o_sync_end,
    output logic                o_sync_status,
    output logic [VSTART_W-1:0] o_sync_vstart,
    output logic                o_busy,
    output logic                o_is_store,
    output logic [CNT_W-1:0]    o_outstanding,
    output logic                o_proto_err
);

    memop_sync_state_t   state;
    logic                fault_flag;
    logic [VSTART_W-1:0] fault_elem;

    logic cnt_next_zero;
    logic cnt_ovf;
    logic cnt_unf;
    logic proto_err_now;
    logic fault_capture;

    tt_outstanding_counter #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .CNT_W           (CNT_W)
    ) u_outstanding_counter (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .inc          (i_req_valid),
        .dec          (i_resp_valid),
        .count        (o_outstanding),
        .next_is_zero (cnt_next_zero),
        .overflow     (cnt_ovf),
        .underflow    (cnt_unf)
    );

    // Only the first fault of a memop is kept, even if a later one has a lower index.
    assign fault_capture = i_resp_valid && i_resp_fault && !fault_flag &&
                           ((state == ACTIVE) || (state == DRAIN));

    always_comb begin
        proto_err_now = cnt_ovf || cnt_unf;
        case (state)
            IDLE:    if (i_sync_start) proto_err_now = 1'b1;
            ACTIVE:  if (i_issue_valid) proto_err_now = 1'b1;
            DRAIN:   if (i_issue_valid || i_sync_start || i_req_valid) proto_err_now = 1'b1;
            END:     if (i_sync_start || i_req_valid) proto_err_now = 1'b1;
            default: proto_err_now = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state         <= IDLE;
            fault_flag    <= 1'b0;
            fault_elem    <= '0;
            o_sync_end    <= 1'b0;
            o_sync_status <= SYNC_OK;
            o_sync_vstart <= '0;
            o_busy        <= 1'b0;
            o_is_store    <= 1'b0;
            o_proto_err   <= 1'b0;
        end else begin
            o_sync_end    <= 1'b0;
            o_sync_status <= SYNC_OK;
            o_sync_vstart <= '0;

            if (proto_err_now) begin
                o_proto_err <= 1'b1;
            end

            if (fault_capture) begin
                fault_flag <= 1'b1;
                fault_elem <= i_resp_elem;
            end

            case (state)
                IDLE: begin
                    if (i_issue_valid) begin
                        state      <= ACTIVE;
                        o_busy     <= 1'b1;
                        o_is_store <= i_issue_store;
                        fault_flag <= 1'b0;
                        fault_elem <= '0;
                    end
                end
                ACTIVE: begin
                    if (i_sync_start) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // A fault arriving on the draining cycle still makes it into the status.
                    if (cnt_next_zero) begin
                        state      <= END;
                        o_sync_end <= 1'b1;
                        if (fault_flag) begin
                            o_sync_status <= SYNC_FAULT;
                            o_sync_vstart <= fault_elem;
                        end else if (fault_capture) begin
                            o_sync_status <= SYNC_FAULT;
                            o_sync_vstart <= i_resp_elem;
                        end
                    end
                end
                END: begin
                    if (i_issue_valid) begin
                        state      <= ACTIVE;
                        o_busy     <= 1'b1;
                        o_is_store <= i_issue_store;
                        fault_flag <= 1'b0;
                        fault_elem <= '0;
                    end else begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tt_memop_sync_responder.sv
// Randomised and directed bench for tt_memop_sync_responder, checked every cycle
// against a behavioural model built from the handshake rules.
module tb_tt_memop_sync_responder;

    localparam int MAX = 16;
    localparam int VW  = 11;
    localparam int CW  = $clog2(MAX + 1);

    localparam int PH_IDLE  = 0;
    localparam int PH_RUN   = 1;
    localparam int PH_WAIT  = 2;
    localparam int PH_DONE  = 3;

    logic          i_clk = 1'b0;
    logic          i_reset_n = 1'b0;
    logic          i_issue_valid = 1'b0;
    logic          i_issue_store = 1'b0;
    logic          i_req_valid = 1'b0;
    logic          i_resp_valid = 1'b0;
    logic          i_resp_fault = 1'b0;
    logic [VW-1:0] i_resp_elem = '0;
    logic          i_sync_start = 1'b0;
    logic          o_sync_end;
    logic          o_sync_status;
    logic [VW-1:0] o_sync_vstart;
    logic          o_busy;
    logic          o_is_store;
    logic [CW-1:0] o_outstanding;
    logic          o_proto_err;

    tt_memop_sync_responder #(
        .MAX_OUTSTANDING (MAX),
        .VSTART_W        (VW)
    ) dut (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_issue_valid (i_issue_valid),
        .i_issue_store (i_issue_store),
        .i_req_valid   (i_req_valid),
        .i_resp_valid  (i_resp_valid),
        .i_resp_fault  (i_resp_fault),
        .i_resp_elem   (i_resp_elem),
        .i_sync_start  (i_sync_start),
        .o_sync_end    (o_sync_end),
        .o_sync_status (o_sync_status),
        .o_sync_vstart (o_sync_vstart),
        .o_busy        (o_busy),
        .o_is_store    (o_is_store),
        .o_outstanding (o_outstanding),
        .o_proto_err   (o_proto_err)
    );

    always #5 i_clk = ~i_clk;

    int n_chk  = 0;
    int n_fail = 0;

    // model state
    int m_ph   = PH_IDLE;
    int m_cnt  = 0;
    bit m_err  = 0;
    bit m_st   = 0;
    bit m_flt  = 0;
    int m_fel  = 0;
    bit e_end  = 0;
    bit e_stat = 0;
    int e_vs   = 0;
    int n_ends = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_tick();
        int nc;
        bit newf;
        if (!i_reset_n) begin
            m_ph = PH_IDLE; m_cnt = 0; m_err = 0; m_st = 0;
            m_flt = 0; m_fel = 0; e_end = 0; e_stat = 0; e_vs = 0;
            return;
        end
        e_end = 0; e_stat = 0; e_vs = 0;
        if (i_sync_start && m_ph != PH_RUN) m_err = 1;
        if (i_req_valid && (m_ph == PH_WAIT || m_ph == PH_DONE)) m_err = 1;
        if (i_issue_valid && (m_ph == PH_RUN || m_ph == PH_WAIT)) m_err = 1;
        nc = m_cnt + int'(i_req_valid) - int'(i_resp_valid);
        if (nc > MAX) begin nc = MAX; m_err = 1; end
        if (nc < 0)   begin nc = 0;   m_err = 1; end
        newf = i_resp_valid && i_resp_fault && !m_flt && (m_ph == PH_RUN || m_ph == PH_WAIT);
        if (newf) begin m_flt = 1; m_fel = int'(i_resp_elem); end
        case (m_ph)
            PH_IDLE: if (i_issue_valid) begin
                m_ph = PH_RUN; m_st = i_issue_store; m_flt = 0; m_fel = 0;
            end
            PH_RUN: if (i_sync_start) m_ph = PH_WAIT;
            PH_WAIT: if (nc == 0) begin
                m_ph = PH_DONE; e_end = 1; e_stat = m_flt; e_vs = m_flt ? m_fel : 0;
            end
            default: if (i_issue_valid) begin
                m_ph = PH_RUN; m_st = i_issue_store; m_flt = 0; m_fel = 0;
            end else begin
                m_ph = PH_IDLE;
            end
        endcase
        m_cnt = nc;
    endtask

    task automatic compare_all();
        check_eq("sync_end",    int'(o_sync_end),    int'(e_end));
        check_eq("sync_status", int'(o_sync_status), int'(e_stat));
        check_eq("sync_vstart", int'(o_sync_vstart), e_vs);
        check_eq("busy",        int'(o_busy),        int'(m_ph != PH_IDLE));
        check_eq("is_store",    int'(o_is_store),    int'(m_st));
        check_eq("outstanding", int'(o_outstanding), m_cnt);
        check_eq("proto_err",   int'(o_proto_err),   int'(m_err));
        if (e_end) n_ends++;
    endtask

    task automatic cyc(input bit iv, input bit is, input bit rq, input bit rs,
                       input bit rf, input int re, input bit ss);
        i_issue_valid = iv;
        i_issue_store = is;
        i_req_valid   = rq;
        i_resp_valid  = rs;
        i_resp_fault  = rf;
        i_resp_elem   = VW'(re);
        i_sync_start  = ss;
        @(posedge i_clk);
        model_tick();
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        i_reset_n = 1'b0;
        idle(2);
        i_reset_n = 1'b1;
    endtask

    initial begin
        int ends_before;
        do_reset();
        idle(1);

        // load, minimal drain
        cyc(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        idle(1);
        check_eq("min_latency_end", int'(o_sync_end), 1);
        idle(1);
        check_eq("busy_after_end", int'(o_busy), 0);

        // store, pending drain
        cyc(1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        for (int k = 1; k <= 10; k++)
            cyc(0, 0, 0, (k == 2 || k == 5 || k == 9), 0, 0, 0);
        check_eq("store_flag", int'(o_is_store), 1);
        idle(2);

        // two faults, first one wins
        ends_before = n_ends;
        cyc(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++)
            cyc(0, 0, 0, 1, (i == 2 || i == 5), (i == 2) ? 5 : ((i == 5) ? 2 : i), 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        idle(1);
        check_eq("first_fault_vstart", int'(o_sync_vstart), 5);
        check_eq("first_fault_status", int'(o_sync_status), 1);
        idle(2);
        check_eq("fault_memop_ended", n_ends - ends_before, 1);

        // protocol errors: underflow then overflow
        do_reset();
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        check_eq("underflow_cnt", int'(o_outstanding), 0);
        idle(3);
        check_eq("err_sticky", int'(o_proto_err), 1);
        do_reset();
        cyc(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < MAX + 1; i++) cyc(0, 0, 1, 0, 0, 0, 0);
        check_eq("overflow_cnt", int'(o_outstanding), MAX);
        cyc(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < MAX; i++) cyc(0, 0, 0, 1, 0, 0, 0);
        idle(2);

        // back-to-back memops, fault cleared for the second one
        do_reset();
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 7, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        idle(1);
        cyc(1, 1, 0, 0, 0, 0, 0);
        check_eq("b2b_busy", int'(o_busy), 1);
        cyc(0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        idle(1);
        check_eq("b2b_status_clear", int'(o_sync_status), 0);
        idle(2);

        // reset while draining with three outstanding
        ends_before = n_ends;
        cyc(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        idle(1);
        do_reset();
        idle(3);
        check_eq("no_end_after_reset", n_ends - ends_before, 0);

        // randomized traffic, mostly legal with occasional violations
        for (int c = 0; c < 4000; c++) begin
            bit legal;
            bit iv, rq, rs, ss;
            legal = ($urandom_range(0, 19) != 0);
            if (legal) begin
                iv = (m_ph == PH_IDLE || m_ph == PH_DONE) && ($urandom_range(0, 3) == 0);
                rq = (m_ph == PH_RUN) && (m_cnt < MAX) && ($urandom_range(0, 2) == 0);
                rs = (m_cnt > 0) && ($urandom_range(0, 2) == 0);
                ss = (m_ph == PH_RUN) && ($urandom_range(0, 9) == 0);
            end else begin
                iv = $urandom_range(0, 1) == 1;
                rq = $urandom_range(0, 1) == 1;
                rs = $urandom_range(0, 1) == 1;
                ss = $urandom_range(0, 1) == 1;
            end
            if ($urandom_range(0, 299) == 0) i_reset_n = 1'b0;
            else i_reset_n = 1'b1;
            cyc(iv, $urandom_range(0, 1) == 1, rq, rs, $urandom_range(0, 4) == 0,
                int'($urandom_range(0, (1 << VW) - 1)), ss);
        end
        i_reset_n = 1'b1;
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
